// File: rtl/avst_lcd_writer.sv
// Avalon-ST video sink driving an 8080-style (ILI9341) TFT controller.
// Pixels pass through a show-ahead FIFO; each packet gets a window preamble, then pixel writes.
module avst_lcd_writer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 512,
    parameter int BUS8       = 0,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int H_RES      = 240,
    parameter int V_RES      = 320
) (
    input  logic              csi_clk50M,
    input  logic              rsi_rst_n,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [DATA_W-1:0] sink_data,
    output logic              sink_ready,
    output logic [15:0]       lcd_data,
    output logic              lcd_rs,
    output logic              lcd_cs,
    output logic              lcd_wr,
    output logic              lcd_rd,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = DATA_W + 2;
    localparam int TOT  = WR_LOW + WR_HIGH;
    localparam int CW   = $clog2(TOT);
    localparam int NPIX = H_RES * V_RES;
    localparam int PW   = $clog2(NPIX + 1);
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] WR_LAST   = CW'(TOT - 1);
    localparam logic [CW-1:0] LOW_END   = CW'(WR_LOW - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(NPIX - 1);
    localparam logic [15:0]   H_LAST    = 16'(H_RES - 1);
    localparam logic [15:0]   V_LAST    = 16'(V_RES - 1);
    localparam bit            IS8       = (BUS8 != 0);

    typedef enum logic [2:0] {
        IDLE, WIN_COL, WIN_PAGE, MEMWR, PIXEL, FLUSH, DONE
    } state_t;

    // FIFO entries are {sop, eop, data}
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, fifo_empty;
    logic [EW-1:0] head;
    logic          head_sop, head_eop;
    logic [15:0]   pix16;

    assign sink_ready = rsi_rst_n && (count_q < FIFO_FULL);
    assign push       = sink_valid && sink_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_sop   = head[EW-1];
    assign head_eop   = head[EW-2];
    assign pix16      = 16'(head[DATA_W-1:0]);

    always_ff @(posedge csi_clk50M) begin
        if (push) mem_q[wr_ptr_q] <= {sink_sop, sink_eop, sink_data};
    end

    always_ff @(posedge csi_clk50M or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!push && pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic          half_q, half_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          cs_q, cs_d, done_q, done_d, err_q, err_d;
    logic          wr_q, rs_q, active_q;
    logic [15:0]   data_q;
    logic [CW-1:0] wcnt_q;
    logic          bus_free, issue, issue_rs;
    logic [15:0]   issue_data, win_last;

    // A new write may be launched in the last cycle of the current one: back-to-back strobes.
    assign bus_free = !active_q || (wcnt_q == WR_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        half_d     = half_q;
        pix_d      = pix_q;
        cs_d       = cs_q;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_rs   = 1'b1;
        issue_data = 16'h0000;
        done_d     = 1'b0;
        err_d      = 1'b0;
        win_last   = (state_q == WIN_COL) ? H_LAST : V_LAST;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                if (head_sop) begin
                    state_d = WIN_COL;
                    idx_d   = 3'd0;
                    cs_d    = 1'b0;
                end else begin
                    pop = 1'b1;
                end
            end
            WIN_COL, WIN_PAGE: if (bus_free) begin
                issue    = 1'b1;
                issue_rs = (idx_q != 3'd0);
                case (idx_q)
                    3'd0:    issue_data = (state_q == WIN_COL) ? 16'h002A : 16'h002B;
                    3'd3:    issue_data = {8'h00, win_last[15:8]};
                    3'd4:    issue_data = {8'h00, win_last[7:0]};
                    default: issue_data = 16'h0000;
                endcase
                if (idx_q == 3'd4) begin
                    idx_d   = 3'd0;
                    state_d = (state_q == WIN_COL) ? WIN_PAGE : MEMWR;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            MEMWR: if (bus_free) begin
                issue      = 1'b1;
                issue_rs   = 1'b0;
                issue_data = 16'h002C;
                pix_d      = '0;
                half_d     = 1'b0;
                state_d    = PIXEL;
            end
            PIXEL: if (bus_free && !fifo_empty) begin
                if (head_sop && pix_q != '0) begin
                    // next packet arrived early: leave it at the head for IDLE
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (IS8 && !half_q) begin
                    issue      = 1'b1;
                    issue_data = {8'h00, pix16[15:8]};
                    half_d     = 1'b1;
                end else begin
                    issue      = 1'b1;
                    issue_data = IS8 ? {8'h00, pix16[7:0]} : pix16;
                    half_d     = 1'b0;
                    pop        = 1'b1;
                    pix_d      = pix_q + PW'(1);
                    if (pix_q == PIX_LAST) begin
                        err_d   = !head_eop;
                        state_d = head_eop ? DONE : FLUSH;
                    end else if (head_eop) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            FLUSH: if (!fifo_empty) begin
                if (head_sop) begin
                    state_d = DONE;
                end else begin
                    pop = 1'b1;
                    if (head_eop) state_d = DONE;
                end
            end
            DONE: if (bus_free) begin
                cs_d    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge csi_clk50M or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 3'd0;
            half_q   <= 1'b0;
            pix_q    <= '0;
            cs_q     <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_q     <= 1'b1;
            rs_q     <= 1'b1;
            data_q   <= 16'h0000;
            active_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            pix_q   <= pix_d;
            cs_q    <= cs_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (issue) begin
                active_q <= 1'b1;
                wcnt_q   <= '0;
                wr_q     <= 1'b0;
                data_q   <= issue_data;
                rs_q     <= issue_rs;
            end else if (active_q) begin
                if (wcnt_q == WR_LAST) begin
                    active_q <= 1'b0;
                    wr_q     <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + CW'(1);
                    wr_q   <= (wcnt_q >= LOW_END);
                end
            end
        end
    end

    assign lcd_data   = data_q;
    assign lcd_rs     = rs_q;
    assign lcd_cs     = cs_q;
    assign lcd_wr     = wr_q;
    assign lcd_rd     = 1'b1;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_avst_lcd_writer.sv
// Directed bench for avst_lcd_writer: 4x2 frame, 16-bit and 8-bit bus, error frames, mid-frame reset.
module tb_avst_lcd_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, s0, e0, r0, rs0, cs0, wr0, rd0, fd0, fe0, bz0;
    logic [15:0] d0, ld0;
    logic        v8, s8, e8, r8, rs8, cs8, wr8, rd8, fd8, fe8, bz8;
    logic [15:0] d8, ld8;

    avst_lcd_writer #(.DATA_W(16), .FIFO_DEPTH(4), .BUS8(0), .WR_LOW(2), .WR_HIGH(2),
                      .H_RES(4), .V_RES(2)) dut (
        .csi_clk50M(clk), .rsi_rst_n(rst_n), .sink_valid(v0), .sink_sop(s0), .sink_eop(e0),
        .sink_data(d0), .sink_ready(r0), .lcd_data(ld0), .lcd_rs(rs0), .lcd_cs(cs0),
        .lcd_wr(wr0), .lcd_rd(rd0), .frame_done(fd0), .frame_err(fe0), .busy(bz0));

    avst_lcd_writer #(.DATA_W(16), .FIFO_DEPTH(4), .BUS8(1), .WR_LOW(2), .WR_HIGH(2),
                      .H_RES(4), .V_RES(2)) dut8 (
        .csi_clk50M(clk), .rsi_rst_n(rst_n), .sink_valid(v8), .sink_sop(s8), .sink_eop(e8),
        .sink_data(d8), .sink_ready(r8), .lcd_data(ld8), .lcd_rs(rs8), .lcd_cs(cs8),
        .lcd_wr(wr8), .lcd_rd(rd8), .frame_done(fd8), .frame_err(fe8), .busy(bz8));

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus monitors: log every WR fall as {rs, data} and track strobe timing.
    int          cyc = 0;
    logic [16:0] log0 [$];
    logic [16:0] log8 [$];
    int          fall_t [$];
    int          stab_err = 0, low_err = 0, cs_err = 0, setup_ok = 0;
    int          done_cnt = 0, err_cnt = 0, done8 = 0;
    bit          m_prev_wr = 1'b1, m_have = 1'b0, m8_prev_wr = 1'b1;
    int          m_low = 0, m_cs_run = 0;
    logic [16:0] m_prev_bus = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_wr = 1'b1; m_have = 1'b0; m_low = 0; m_cs_run = 0;
        end else begin
            if (m_prev_wr && !wr0) begin
                log0.push_back({rs0, ld0});
                fall_t.push_back(cyc);
                if (cs0) cs_err++;
                if (m_cs_run == 1) setup_ok++;
                m_low = 1;
            end else begin
                if (!wr0) m_low++;
                if (m_have && {rs0, ld0} != m_prev_bus) stab_err++;
                if (!m_prev_wr && wr0 && m_low != 2) low_err++;
            end
            m_cs_run   = cs0 ? 0 : m_cs_run + 1;
            m_prev_wr  = wr0;
            m_prev_bus = {rs0, ld0};
            m_have     = 1'b1;
            if (fd0) done_cnt++;
            if (fe0) err_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            m8_prev_wr = 1'b1;
        end else begin
            if (m8_prev_wr && !wr8) log8.push_back({rs8, ld8});
            m8_prev_wr = wr8;
            if (fd8) done8++;
        end
    end

    logic [16:0] exp_q [$];

    task automatic add_pre();
        logic [16:0] pre [11];
        pre = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h10003,
                17'h0002B, 17'h10000, 17'h10000, 17'h10000, 17'h10001, 17'h0002C};
        for (int i = 0; i < 11; i++) exp_q.push_back(pre[i]);
    endtask

    task automatic add_pix(input logic [15:0] d);
        exp_q.push_back({1'b1, d});
    endtask

    task automatic add_pix8(input logic [15:0] d);
        exp_q.push_back({1'b1, 8'h00, d[15:8]});
        exp_q.push_back({1'b1, 8'h00, d[7:0]});
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input bit which, input logic [15:0] d, input bit s, input bit e);
        int n = 0;
        if (which) begin v8 = 1'b1; d8 = d; s8 = s; e8 = e; end
        else       begin v0 = 1'b1; d0 = d; s0 = s; e0 = e; end
        while (!(which ? r8 : r0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        expect_eq("send_ready", which ? r8 : r0, 1);
        @(negedge clk);
        if (which) v8 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int target, input string tag);
        int n = 0;
        while ((which ? done8 : done_cnt) < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        expect_eq(tag, which ? done8 : done_cnt, target);
    endtask

    task automatic cmp_log(input bit which, input int base, input string tag);
        int n;
        n = (which ? log8.size() : log0.size()) - base;
        expect_eq({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            expect_eq($sformatf("%s[%0d]", tag, i), which ? log8[base+i] : log0[base+i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        int b_log, b_done, b_err, b_setup, bad_gap, n;
        logic [15:0] px8 [8];
        px8 = '{16'hF81F, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E};
        rst_n = 1'b0;
        v0 = 0; s0 = 0; e0 = 0; d0 = '0;
        v8 = 0; s8 = 0; e8 = 0; d8 = '0;
        repeat (3) @(negedge clk);
        expect_eq("rst_ready", r0, 0);
        expect_eq("rst_ready8", r8, 0);
        expect_eq("rst_cs", cs0, 1);
        expect_eq("rst_wr", wr0, 1);
        expect_eq("rst_rd", rd0, 1);
        expect_eq("rst_rs", rs0, 1);
        expect_eq("rst_data", ld0, 0);
        expect_eq("rst_done", fd0, 0);
        expect_eq("rst_err", fe0, 0);
        expect_eq("rst_busy", bz0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_eq("ready_after_rst", r0, 1);

        // Clean frame with two leading junk beats and FIFO backpressure.
        b_log = log0.size(); b_done = done_cnt; b_err = err_cnt; b_setup = setup_ok;
        send(0, 16'hDEAD, 0, 0);
        send(0, 16'hBEEF, 0, 1);
        for (int k = 1; k <= 4; k++) send(0, 16'(k), k == 1, 0);
        expect_eq("full_ready", r0, 0);
        for (int k = 5; k <= 8; k++) send(0, 16'(k), 0, k == 8);
        wait_done(0, b_done + 1, "t1_done");
        add_pre();
        for (int k = 1; k <= 8; k++) add_pix(16'(k));
        cmp_log(0, b_log, "t1");
        expect_eq("t1_err", err_cnt, b_err);
        expect_eq("t1_cs_setup", setup_ok, b_setup + 1);
        bad_gap = 0;
        for (int i = b_log + 1; i < fall_t.size(); i++)
            if (fall_t[i] - fall_t[i-1] != 4) bad_gap++;
        expect_eq("t1_wr_period", bad_gap, 0);

        // 8-bit bus: high byte then low byte per pixel.
        send(1, px8[0], 1, 0);
        for (int k = 1; k < 8; k++) send(1, px8[k], 0, k == 7);
        wait_done(1, 1, "b8_done");
        add_pre();
        for (int k = 0; k < 8; k++) add_pix8(px8[k]);
        cmp_log(1, 0, "b8");

        // Short frame: eop on pixel 5.
        b_log = log0.size(); b_done = done_cnt; b_err = err_cnt;
        for (int k = 1; k <= 5; k++) send(0, 16'h0010 + 16'(k), k == 1, k == 5);
        wait_done(0, b_done + 1, "short_done");
        add_pre();
        for (int k = 1; k <= 5; k++) add_pix(16'h0010 + 16'(k));
        cmp_log(0, b_log, "short");
        expect_eq("short_err", err_cnt, b_err + 1);

        // Long frame: 10 beats, last two flushed.
        b_log = log0.size(); b_done = done_cnt; b_err = err_cnt;
        for (int k = 1; k <= 10; k++) send(0, 16'h0020 + 16'(k), k == 1, k == 10);
        wait_done(0, b_done + 1, "long_done");
        add_pre();
        for (int k = 1; k <= 8; k++) add_pix(16'h0020 + 16'(k));
        cmp_log(0, b_log, "long");
        expect_eq("long_err", err_cnt, b_err + 1);
        @(negedge clk);
        expect_eq("long_idle_busy", bz0, 0);

        // Early sop after 3 pixels aborts the frame and starts the next one.
        b_log = log0.size(); b_done = done_cnt; b_err = err_cnt;
        for (int k = 1; k <= 3; k++) send(0, 16'h0030 + 16'(k), k == 1, 0);
        for (int k = 1; k <= 8; k++) send(0, 16'h0040 + 16'(k), k == 1, k == 8);
        wait_done(0, b_done + 2, "sop_done");
        add_pre();
        for (int k = 1; k <= 3; k++) add_pix(16'h0030 + 16'(k));
        add_pre();
        for (int k = 1; k <= 8; k++) add_pix(16'h0040 + 16'(k));
        cmp_log(0, b_log, "sop");
        expect_eq("sop_err", err_cnt, b_err + 1);

        // Reset during pixel 3, then a clean frame.
        b_log = log0.size(); b_err = err_cnt;
        for (int k = 1; k <= 4; k++) send(0, 16'h0050 + 16'(k), k == 1, 0);
        n = 0;
        while (log0.size() < b_log + 14 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        expect_eq("rst_mid_reached", log0.size() - b_log, 14);
        rst_n = 1'b0;
        #1;
        expect_eq("rst_mid_cs", cs0, 1);
        expect_eq("rst_mid_wr", wr0, 1);
        expect_eq("rst_mid_ready", r0, 0);
        expect_eq("rst_mid_busy", bz0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b_log = log0.size(); b_done = done_cnt;
        for (int k = 1; k <= 8; k++) send(0, 16'h0060 + 16'(k), k == 1, k == 8);
        wait_done(0, b_done + 1, "post_rst_done");
        add_pre();
        for (int k = 1; k <= 8; k++) add_pix(16'h0060 + 16'(k));
        cmp_log(0, b_log, "post_rst");
        expect_eq("post_rst_err", err_cnt, b_err);

        expect_eq("bus_stable", stab_err, 0);
        expect_eq("wr_low_len", low_err, 0);
        expect_eq("cs_low_on_wr", cs_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
